// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main control FSM.
package mc_pkg;

   // Control FSM states
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   // Opcodes (instr[6:0])
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // aluOp encodings
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // aluSrcA encodings
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // aluSrcB encodings
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // resultSrc encodings
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Datapath control bundle produced by the state decode
   typedef struct packed {
      logic [1:0] aluOp;
      logic       branch;
      logic       pcUpdate;
      logic       irWrite;
      logic       regWrite;
      logic       memWrite;
      logic       memRead;
      logic       adrSrc;
      logic [1:0] aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] resultSrc;
      logic       selOp;
      logic       trap;
   } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the main FSM and the shared datapath / memory.
//
// Handshake: memRead/memWrite are requests held high every cycle until the
// memory answers; memReady high in a cycle completes the access in that same
// cycle. memReady is only honoured when stall is low, so a memory that raises
// memReady during a stall must raise it again afterwards.
interface mc_control_fsm_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       op;
   logic             memReady;
   logic             stall;
   logic [1:0]       aluOp;
   logic             branch;
   logic             pcUpdate;
   logic             irWrite;
   logic             regWrite;
   logic             memWrite;
   logic             memRead;
   logic             adrSrc;
   logic [1:0]       aluSrcA;
   logic [1:0]       aluSrcB;
   logic [1:0]       resultSrc;
   logic             selOp;
   logic             trap;
   logic [CNT_W-1:0] instrCount;

   // Controller side
   modport master (
      input  op, memReady, stall,
      output aluOp, branch, pcUpdate, irWrite, regWrite, memWrite, memRead,
             adrSrc, aluSrcA, aluSrcB, resultSrc, selOp, trap, instrCount
   );

   // Datapath / memory side
   modport slave (
      output op, memReady, stall,
      input  aluOp, branch, pcUpdate, irWrite, regWrite, memWrite, memRead,
             adrSrc, aluSrcA, aluSrcB, resultSrc, selOp, trap, instrCount
   );
endinterface

// File: rtl/mc_control_fsm_state_decode.sv
// Combinational Moore decode of the control state into the datapath bundle.
module mc_state_decode
   import mc_pkg::*;
(
   input  state_t i_state,
   input  logic   i_mem_ready,
   input  logic   i_stall,
   output ctrl_t  o_ctrl
);

   // State to control-bundle decode; anything not set for a state stays 0
   always_comb begin
      o_ctrl       = '0;
      o_ctrl.selOp = i_stall;
      case (i_state)
         S_FETCH: begin
            o_ctrl.memRead   = 1'b1;
            o_ctrl.adrSrc    = 1'b0;
            o_ctrl.aluSrcA   = SRCA_PC;
            o_ctrl.aluSrcB   = SRCB_FOUR;
            o_ctrl.aluOp     = ALUOP_ADD;
            o_ctrl.resultSrc = RES_ALURESULT;
            // IR load and PC+4 only commit once the fetch has data
            o_ctrl.irWrite   = i_mem_ready;
            o_ctrl.pcUpdate  = i_mem_ready;
         end
         S_DECODE: begin
            o_ctrl.aluSrcA = SRCA_OLDPC;
            o_ctrl.aluSrcB = SRCB_IMM;
            o_ctrl.aluOp   = ALUOP_ADD;
         end
         S_MEMADR: begin
            o_ctrl.aluSrcA = SRCA_RS1;
            o_ctrl.aluSrcB = SRCB_IMM;
            o_ctrl.aluOp   = ALUOP_ADD;
         end
         S_MEMREAD: begin
            o_ctrl.memRead = 1'b1;
            o_ctrl.adrSrc  = 1'b1;
         end
         S_MEMWB: begin
            o_ctrl.resultSrc = RES_MEMDATA;
            o_ctrl.regWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            o_ctrl.memWrite = 1'b1;
            o_ctrl.adrSrc   = 1'b1;
         end
         S_EXECUTER: begin
            o_ctrl.aluSrcA = SRCA_RS1;
            o_ctrl.aluSrcB = SRCB_RS2;
            o_ctrl.aluOp   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            o_ctrl.aluSrcA = SRCA_RS1;
            o_ctrl.aluSrcB = SRCB_IMM;
            o_ctrl.aluOp   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            o_ctrl.resultSrc = RES_ALUOUT;
            o_ctrl.regWrite  = 1'b1;
         end
         S_BEQ: begin
            o_ctrl.aluSrcA = SRCA_RS1;
            o_ctrl.aluSrcB = SRCB_RS2;
            o_ctrl.aluOp   = ALUOP_SUB;
            o_ctrl.branch  = 1'b1;
         end
         S_JAL: begin
            o_ctrl.aluSrcA   = SRCA_OLDPC;
            o_ctrl.aluSrcB   = SRCB_FOUR;
            o_ctrl.aluOp     = ALUOP_ADD;
            o_ctrl.resultSrc = RES_ALUOUT;
            o_ctrl.pcUpdate  = 1'b1;
         end
         S_TRAP: begin
            o_ctrl.trap = 1'b1;
         end
         default: begin
            o_ctrl.trap = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequencing, wait states,
// stalls, illegal-opcode trap and retired-instruction counting.
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter bit TRAP_STICKY = 1'b1
)(
   input  logic               clk,
   input  logic               reset,
   mc_control_fsm_if.master   bus,
   output state_t             o_dbg_state
);

   state_t           r_state;
   state_t           w_next_state;
   logic             w_retire;
   logic [CNT_W-1:0] r_instr_count;
   ctrl_t            w_ctrl;

   // Next-state and retirement decision; stall freezes everything
   always_comb begin
      w_next_state = r_state;
      w_retire     = 1'b0;
      if (!bus.stall) begin
         case (r_state)
            S_FETCH: begin
               if (bus.memReady) w_next_state = S_DECODE;
            end
            S_DECODE: begin
               case (bus.op)
                  OP_LW,
                  OP_SW:   w_next_state = S_MEMADR;
                  OP_R:    w_next_state = S_EXECUTER;
                  OP_I:    w_next_state = S_EXECUTEI;
                  OP_BEQ:  w_next_state = S_BEQ;
                  OP_JAL:  w_next_state = S_JAL;
                  default: w_next_state = S_TRAP;
               endcase
            end
            S_MEMADR: begin
               w_next_state = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
               if (bus.memReady) w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
               w_next_state = S_FETCH;
               w_retire     = 1'b1;
            end
            S_MEMWRITE: begin
               if (bus.memReady) begin
                  w_next_state = S_FETCH;
                  w_retire     = 1'b1;
               end
            end
            S_EXECUTER,
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_ALUWB: begin
               w_next_state = S_FETCH;
               w_retire     = 1'b1;
            end
            S_BEQ: begin
               w_next_state = S_FETCH;
               w_retire     = 1'b1;
            end
            // JAL retires later through ALUWB (rd = PC+4)
            S_JAL: w_next_state = S_ALUWB;
            S_TRAP: begin
               if (!TRAP_STICKY) w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
         endcase
      end
   end

   // State register and wrapping retired-instruction counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_FETCH;
         r_instr_count <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_retire) r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   mc_state_decode u_decode (
      .i_state     (r_state),
      .i_mem_ready (bus.memReady),
      .i_stall     (bus.stall),
      .o_ctrl      (w_ctrl)
   );

   assign bus.aluOp      = w_ctrl.aluOp;
   assign bus.branch     = w_ctrl.branch;
   assign bus.pcUpdate   = w_ctrl.pcUpdate;
   assign bus.irWrite    = w_ctrl.irWrite;
   assign bus.regWrite   = w_ctrl.regWrite;
   assign bus.memWrite   = w_ctrl.memWrite;
   assign bus.memRead    = w_ctrl.memRead;
   assign bus.adrSrc     = w_ctrl.adrSrc;
   assign bus.aluSrcA    = w_ctrl.aluSrcA;
   assign bus.aluSrcB    = w_ctrl.aluSrcB;
   assign bus.resultSrc  = w_ctrl.resultSrc;
   assign bus.selOp      = w_ctrl.selOp;
   assign bus.trap       = w_ctrl.trap;
   assign bus.instrCount = r_instr_count;
   assign o_dbg_state    = r_state;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Main control state machine for the multi-cycle RV32I core. It decodes the opcode latched in the instruction register and steps the shared datapath through fetch, decode, execute, memory and writeback. It drives the datapath control bundle, including the bubble select consumed by the control-zeroing mux. It also handles memory wait states, external stalls, illegal opcodes and the retired-instruction count.

Parameters:
CNT_W, 32, width of retired-instruction counter
TRAP_STICKY, 1, 1 = TRAP state held until reset; 0 = TRAP returns to FETCH after one cycle

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
op  in  7  opcode field from instruction register (instr[6:0])
memReady  in  1  memory handshake; access completes in the cycle it is high
stall  in  1  external hold request
aluOp  out  2  00 add, 01 sub/compare, 10 funct-decoded
branch  out  1  conditional PC write enable (ANDed with zero outside)
pcUpdate  out  1  unconditional PC write enable
irWrite  out  1  instruction register load
regWrite  out  1  register file write enable
memWrite  out  1  data memory write request
memRead  out  1  memory read request
adrSrc  out  1  0 = PC, 1 = ALUOut as memory address
aluSrcA  out  2  00 PC, 01 oldPC, 10 rs1
aluSrcB  out  2  00 rs2, 01 imm, 10 constant 4
resultSrc  out  2  00 ALUOut, 01 memData, 10 ALU result
selOp  out  1  1 = bubble: downstream mux forces control to zero
trap  out  1  illegal opcode flag
instrCount  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP.
- Outputs are a Moore decode of the state register (no output registers). Exceptions: irWrite and pcUpdate in FETCH are qualified by memReady. All outputs not listed for a state are 0.
- Reset:
  - On reset, state = FETCH and instrCount = 0.
  - The cycle after reset shows FETCH decode: memRead=1, aluSrcB=10, resultSrc=10, adrSrc=0, irWrite/pcUpdate = memReady.
  - trap=0 and selOp=0 after reset.
  - Reset mid-operation aborts any access; no write enable is asserted in the reset cycle or the following cycle unless the state requires it.
- FETCH: memRead=1, adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10. Moves to DECODE when memReady=1; otherwise holds.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch/jump target).
  - Next state by op: 0000011 → MEMADR, 0100011 → MEMADR, 0110011 → EXECUTER, 0010011 → EXECUTEI, 1100011 → BEQ, 1101111 → JAL, any other → TRAP.
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. Goes to MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: memRead=1, adrSrc=1. Moves to MEMWB on memReady; otherwise holds.
- MEMWB: resultSrc=01, regWrite=1. Returns to FETCH.
- MEMWRITE: memWrite=1, adrSrc=1. Request is held every cycle until memReady, then returns to FETCH.
- EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10. Goes to ALUWB.
- EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10. Goes to ALUWB.
- ALUWB: resultSrc=00, regWrite=1. Returns to FETCH.
- BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, branch=1. Returns to FETCH.
- JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1. Goes to ALUWB (writes rd = PC+4).
- TRAP: trap=1, all enables 0. Holds if TRAP_STICKY=1; otherwise returns to FETCH after one cycle.
- Stall:
  - While stall=1, the state holds and selOp=1.
  - Control outputs still show the state decode; the downstream mux zeroes them.
  - stall has priority over memReady. A memReady arriving during stall is ignored, and the memory must re-assert it.
- Retirement: instrCount increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. JAL counts once, via ALUWB. The counter wraps modulo 2^CNT_W.
- Latency without wait states or stalls: lw 5 cycles, sw 4, R/I-type 4, beq 3, jal 4.

Decomposition:
- Shared package mc_pkg holds:
  - state enum typedef
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - aluOp, aluSrcA, aluSrcB and resultSrc encoding constants
- Natural sub-module: mc_state_decode, a combinational state → control-bundle decode, kept separate from the next-state/counter logic.

Test Plan:
- Reset, then lw with memReady tied high → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. regWrite=1 only in cycle 5 with resultSrc=01; instrCount=1.
- sw with memReady low for 3 cycles in MEMWRITE → memWrite=1 for 4 consecutive cycles. Return to FETCH the cycle after memReady; instrCount +1.
- add, addi, beq, jal back-to-back, no stalls → total 15 cycles; instrCount=4. branch=1 only in the BEQ cycle; pcUpdate=1 in the JAL cycle.
- stall=1 for 2 cycles in EXECUTER with memReady=1 → state unchanged and selOp=1 in both cycles. ALUWB follows one cycle after stall drops.
- op=0000000 in DECODE, TRAP_STICKY=1 → trap=1 held with all enables 0. Reset returns to FETCH with trap=0 and instrCount=0.
- instrCount preloaded near max (CNT_W=4, 15 retirements), then one more addi → instrCount wraps to 0.
